// File: rtl/binary_mask_render.sv
// binary_mask_render: renders the 1-bit skin mask as 12-bit RGB through a two-stage pipeline
// and measures per-frame foreground count and bounding box. MASK_OVERLAY_BOX_EN draws the latched box edges in red.
module binary_mask_render #(
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter logic [11:0] FG_LEVEL = 12'hFFF,
    parameter logic [11:0] BG_LEVEL = 12'h000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iBinary,
    input  logic        iDVAL,
    input  logic        iFrame_Start,
    output logic [11:0] oRed,
    output logic [11:0] oGreen,
    output logic [11:0] oBlue,
    output logic        oDVAL,
    output logic [18:0] oCount,
    output logic [9:0]  oMinX,
    output logic [9:0]  oMaxX,
    output logic [9:0]  oMinY,
    output logic [9:0]  oMaxY,
    output logic        oBoxValid,
    output logic        oStatValid
);

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic [9:0] minU10(input logic [9:0] a, input logic [9:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [9:0] maxU10(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t      state_r, stateNext_s;
    logic [9:0]  xCnt_r, yCnt_r, xNext_s, yNext_s;
    logic [18:0] accCount_r, accCountNext_s, baseCount_s;
    logic [9:0]  accMinX_r, accMaxX_r, accMinY_r, accMaxY_r;
    logic [9:0]  accMinXNext_s, accMaxXNext_s, accMinYNext_s, accMaxYNext_s;
    logic [9:0]  baseMinX_s, baseMaxX_s, baseMinY_s, baseMaxY_s;
    logic [9:0]  curX_s, curY_s;
    logic        startNow_s, inFrame_s, beatCounted_s, lastBeat_s;
    logic        s1Valid_r, s1Pix_r;
    logic        onBox_s;
    logic [11:0] redNext_s, greenNext_s, blueNext_s;

    // Frame tracking: coordinate of the current beat, accumulator update and next FSM state.
    always_comb begin
        startNow_s    = iFrame_Start && (state_r != DONE);
        inFrame_s     = startNow_s || (state_r == ACTIVE);
        beatCounted_s = inFrame_s && iDVAL;

        // A start (outside DONE) makes this cycle's beat pixel (0,0) of a fresh frame.
        if (startNow_s) begin
            curX_s      = 10'd0;
            curY_s      = 10'd0;
            baseCount_s = 19'd0;
            baseMinX_s  = 10'h3FF;
            baseMaxX_s  = 10'd0;
            baseMinY_s  = 10'h3FF;
            baseMaxY_s  = 10'd0;
        end else begin
            curX_s      = xCnt_r;
            curY_s      = yCnt_r;
            baseCount_s = accCount_r;
            baseMinX_s  = accMinX_r;
            baseMaxX_s  = accMaxX_r;
            baseMinY_s  = accMinY_r;
            baseMaxY_s  = accMaxY_r;
        end

        lastBeat_s = beatCounted_s && (curX_s == X_LAST) && (curY_s == Y_LAST);

        if (beatCounted_s && iBinary) begin
            accCountNext_s = baseCount_s + 19'd1;
            accMinXNext_s  = minU10(baseMinX_s, curX_s);
            accMaxXNext_s  = maxU10(baseMaxX_s, curX_s);
            accMinYNext_s  = minU10(baseMinY_s, curY_s);
            accMaxYNext_s  = maxU10(baseMaxY_s, curY_s);
        end else begin
            accCountNext_s = baseCount_s;
            accMinXNext_s  = baseMinX_s;
            accMaxXNext_s  = baseMaxX_s;
            accMinYNext_s  = baseMinY_s;
            accMaxYNext_s  = baseMaxY_s;
        end

        if (beatCounted_s && (curX_s == X_LAST)) begin
            xNext_s = 10'd0;
            yNext_s = curY_s + 10'd1;
        end else if (beatCounted_s) begin
            xNext_s = curX_s + 10'd1;
            yNext_s = curY_s;
        end else begin
            xNext_s = curX_s;
            yNext_s = curY_s;
        end

        stateNext_s = IDLE;
        case (state_r)
            IDLE: begin
                if (lastBeat_s) begin
                    stateNext_s = DONE;
                end else if (startNow_s) begin
                    stateNext_s = ACTIVE;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            ACTIVE: begin
                if (lastBeat_s) begin
                    stateNext_s = DONE;
                end else begin
                    stateNext_s = ACTIVE;
                end
            end
            DONE: begin
                if (iFrame_Start) begin
                    stateNext_s = ACTIVE;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            default: stateNext_s = IDLE;
        endcase
    end

    // FSM state, coordinate counters and accumulators; DONE leaves everything clear for the next frame.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_r    <= IDLE;
            xCnt_r     <= 10'd0;
            yCnt_r     <= 10'd0;
            accCount_r <= 19'd0;
            accMinX_r  <= 10'h3FF;
            accMaxX_r  <= 10'd0;
            accMinY_r  <= 10'h3FF;
            accMaxY_r  <= 10'd0;
        end else if (state_r == DONE) begin
            state_r    <= stateNext_s;
            xCnt_r     <= 10'd0;
            yCnt_r     <= 10'd0;
            accCount_r <= 19'd0;
            accMinX_r  <= 10'h3FF;
            accMaxX_r  <= 10'd0;
            accMinY_r  <= 10'h3FF;
            accMaxY_r  <= 10'd0;
        end else begin
            state_r    <= stateNext_s;
            xCnt_r     <= xNext_s;
            yCnt_r     <= yNext_s;
            accCount_r <= accCountNext_s;
            accMinX_r  <= accMinXNext_s;
            accMaxX_r  <= accMaxXNext_s;
            accMinY_r  <= accMinYNext_s;
            accMaxY_r  <= accMaxYNext_s;
        end
    end

    // Statistics latch: loaded at the last-pixel edge so the pulse cycle already shows the new values.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oCount     <= 19'd0;
            oMinX      <= 10'd0;
            oMaxX      <= 10'd0;
            oMinY      <= 10'd0;
            oMaxY      <= 10'd0;
            oBoxValid  <= 1'b0;
            oStatValid <= 1'b0;
        end else begin
            oStatValid <= lastBeat_s;
            if (lastBeat_s && (accCountNext_s != 19'd0)) begin
                oCount    <= accCountNext_s;
                oMinX     <= accMinXNext_s;
                oMaxX     <= accMaxXNext_s;
                oMinY     <= accMinYNext_s;
                oMaxY     <= accMaxYNext_s;
                oBoxValid <= 1'b1;
            end else if (lastBeat_s) begin
                oCount    <= 19'd0;
                oMinX     <= 10'd0;
                oMaxX     <= 10'd0;
                oMinY     <= 10'd0;
                oMaxY     <= 10'd0;
                oBoxValid <= 1'b0;
            end else begin
                oCount    <= oCount;
                oMinX     <= oMinX;
                oMaxX     <= oMaxX;
                oMinY     <= oMinY;
                oMaxY     <= oMaxY;
                oBoxValid <= oBoxValid;
            end
        end
    end

    // Stage 1: register the pixel and its valid flag.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s1Valid_r <= 1'b0;
            s1Pix_r   <= 1'b0;
        end else begin
            s1Valid_r <= iDVAL;
            s1Pix_r   <= iBinary;
        end
    end

`ifdef MASK_OVERLAY_BOX_EN
    logic [9:0] s1X_r, s1Y_r;

    // Stage 1 coordinate; beats outside a frame carry (0,0).
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s1X_r <= 10'd0;
            s1Y_r <= 10'd0;
        end else if (beatCounted_s) begin
            s1X_r <= curX_s;
            s1Y_r <= curY_s;
        end else begin
            s1X_r <= 10'd0;
            s1Y_r <= 10'd0;
        end
    end

    // Box-edge hit test against the currently latched statistics.
    always_comb begin
        onBox_s = oBoxValid &&
                  ((((s1X_r == oMinX) || (s1X_r == oMaxX)) && (s1Y_r >= oMinY) && (s1Y_r <= oMaxY)) ||
                   (((s1Y_r == oMinY) || (s1Y_r == oMaxY)) && (s1X_r >= oMinX) && (s1X_r <= oMaxX)));
    end
`else
    assign onBox_s = 1'b0;
`endif

    // Colour selection for stage 2.
    always_comb begin
        if (onBox_s) begin
            redNext_s   = 12'hFFF;
            greenNext_s = 12'h000;
            blueNext_s  = 12'h000;
        end else if (s1Pix_r) begin
            redNext_s   = FG_LEVEL;
            greenNext_s = FG_LEVEL;
            blueNext_s  = FG_LEVEL;
        end else begin
            redNext_s   = BG_LEVEL;
            greenNext_s = BG_LEVEL;
            blueNext_s  = BG_LEVEL;
        end
    end

    // Stage 2: registered colour and valid.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oRed   <= 12'h000;
            oGreen <= 12'h000;
            oBlue  <= 12'h000;
            oDVAL  <= 1'b0;
        end else begin
            oRed   <= redNext_s;
            oGreen <= greenNext_s;
            oBlue  <= blueNext_s;
            oDVAL  <= s1Valid_r;
        end
    end

endmodule

// File: tb/tb_binary_mask_render.sv
// Scoreboard bench for binary_mask_render on a 4x2 frame: a frame-level model predicts every
// rendered pixel and every statistics pulse; a monitor compares them as the DUT presents them.
module tb_binary_mask_render;

    localparam int          H    = 4;
    localparam int          V    = 2;
    localparam int          NPIX = H * V;
    localparam logic [11:0] FG   = 12'hFFF;
    localparam logic [11:0] BG   = 12'h000;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iBinary = 1'b0;
    logic        iDVAL = 1'b0;
    logic        iFrame_Start = 1'b0;
    logic [11:0] oRed, oGreen, oBlue;
    logic        oDVAL;
    logic [18:0] oCount;
    logic [9:0]  oMinX, oMaxX, oMinY, oMaxY;
    logic        oBoxValid, oStatValid;

    binary_mask_render #(.H_ACTIVE(H), .V_ACTIVE(V), .FG_LEVEL(FG), .BG_LEVEL(BG)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iBinary(iBinary), .iDVAL(iDVAL), .iFrame_Start(iFrame_Start),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oDVAL(oDVAL), .oCount(oCount),
        .oMinX(oMinX), .oMaxX(oMaxX), .oMinY(oMinY), .oMaxY(oMaxY),
        .oBoxValid(oBoxValid), .oStatValid(oStatValid)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int   due;
        logic bin;
        int   x;
        int   y;
    } pix_t;

    typedef struct {
        int   due;
        int   cnt;
        int   minx;
        int   maxx;
        int   miny;
        int   maxy;
        logic bv;
    } stat_t;

    pix_t  pixQ[$];
    stat_t statQ[$];
    stat_t mb;
    int    edgeCnt = 0;
    int    checks = 0;
    int    passes = 0;

    // frame-level model state
    bit    mActive = 1'b0;
    bit    mDone = 1'b0;
    int    mBeat = 0;
    bit    frameBits[NPIX];

    task automatic chk(input string name, input logic ok, input string info);
        checks++;
        if (ok === 1'b1) passes++;
        else $display("FAIL %s: %s", name, info);
    endtask

    function automatic logic [35:0] expColour(input logic bin, input int x, input int y);
`ifdef MASK_OVERLAY_BOX_EN
        if (mb.bv && ((((x == mb.minx) || (x == mb.maxx)) && (y >= mb.miny) && (y <= mb.maxy)) ||
                      (((y == mb.miny) || (y == mb.maxy)) && (x >= mb.minx) && (x <= mb.maxx))))
            return {12'hFFF, 12'h000, 12'h000};
`endif
        return bin ? {FG, FG, FG} : {BG, BG, BG};
    endfunction

    function automatic void clearBox();
        mb.due = 0; mb.cnt = 0; mb.minx = 0; mb.maxx = 0; mb.miny = 0; mb.maxy = 0; mb.bv = 1'b0;
    endfunction

    // Statistics of the just-completed frame, computed by scanning the whole frame.
    function automatic void pushStats(input int due);
        stat_t s;
        s.due = due; s.cnt = 0;
        s.minx = H; s.maxx = -1; s.miny = V; s.maxy = -1;
        for (int i = 0; i < NPIX; i++) begin
            if (frameBits[i]) begin
                s.cnt++;
                if (i % H < s.minx) s.minx = i % H;
                if (i % H > s.maxx) s.maxx = i % H;
                if (i / H < s.miny) s.miny = i / H;
                if (i / H > s.maxy) s.maxy = i / H;
            end
        end
        s.bv = (s.cnt != 0);
        if (s.cnt == 0) begin
            s.minx = 0; s.maxx = 0; s.miny = 0; s.maxy = 0;
        end
        statQ.push_back(s);
    endfunction

    // One driven cycle: apply inputs, then advance the frame model.
    task automatic cyc(input logic s, input logic d, input logic b);
        int   e;
        pix_t p;
        @(negedge iCLK);
        iFrame_Start = s; iDVAL = d; iBinary = b;
        e = edgeCnt + 1;
        p.x = 0; p.y = 0; p.bin = b; p.due = e + 1;
        if (mDone) begin
            mDone = 1'b0;
            if (s) begin
                mActive = 1'b1; mBeat = 0;
                for (int i = 0; i < NPIX; i++) frameBits[i] = 1'b0;
            end
        end else begin
            if (s) begin
                mActive = 1'b1; mBeat = 0;
                for (int i = 0; i < NPIX; i++) frameBits[i] = 1'b0;
            end
            if (d && mActive) begin
                p.x = mBeat % H; p.y = mBeat / H;
                frameBits[mBeat] = b;
                mBeat++;
                if (mBeat == NPIX) begin
                    pushStats(e);
                    mActive = 1'b0;
                    mDone = 1'b1;
                end
            end
        end
        if (d) pixQ.push_back(p);
    endtask

    // mode 0: start alone then beats; 1: start with first beat; 2: no start. gap<0 picks random gaps.
    task automatic frame(input logic [NPIX-1:0] bits, input int mode, input int gap);
        int g;
        for (int i = 0; i < NPIX; i++) begin
            if (i == 0 && mode == 0) cyc(1'b1, 1'b0, 1'b0);
            cyc((i == 0 && mode == 1), 1'b1, bits[i]);
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            if (i != NPIX - 1) repeat (g) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic checkAllZero(input string name);
        chk({name, "_pix"}, ({oRed, oGreen, oBlue, oDVAL} === 37'd0),
            $sformatf("rgb=%h/%h/%h dval=%b, required all 0", oRed, oGreen, oBlue, oDVAL));
        chk({name, "_stat"}, ({oCount, oMinX, oMaxX, oMinY, oMaxY, oBoxValid, oStatValid} === 61'd0),
            $sformatf("cnt=%0d box=%0d,%0d,%0d,%0d bv=%b sv=%b, required all 0",
                      oCount, oMinX, oMaxX, oMinY, oMaxY, oBoxValid, oStatValid));
    endtask

    // Asynchronous reset in the middle of a cycle; scoreboard and model restart with it.
    task automatic doReset();
        @(negedge iCLK);
        #2 iRST_N = 1'b0;
        iDVAL = 1'b0; iFrame_Start = 1'b0;
        #1 checkAllZero("async_reset");
        pixQ.delete(); statQ.delete();
        mActive = 1'b0; mDone = 1'b0; mBeat = 0;
        clearBox();
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
    endtask

    // Monitor: pops expected pixels/statistics whenever they fall due and compares.
    initial begin
        pix_t  p;
        stat_t s;
        logic  expP, expS;
        forever begin
            @(posedge iCLK);
            edgeCnt++;
            #1;
            if (!iRST_N) continue;
            expP = (pixQ.size() > 0) && (pixQ[0].due == edgeCnt);
            chk("odval", (oDVAL === expP), $sformatf("edge %0d oDVAL=%b required %b", edgeCnt, oDVAL, expP));
            if (expP) begin
                p = pixQ.pop_front();
                chk("colour", ({oRed, oGreen, oBlue} === expColour(p.bin, p.x, p.y)),
                    $sformatf("pix(%0d,%0d) bin=%b got %h required %h", p.x, p.y, p.bin,
                              {oRed, oGreen, oBlue}, expColour(p.bin, p.x, p.y)));
            end
            while ((pixQ.size() > 0) && (pixQ[0].due < edgeCnt)) void'(pixQ.pop_front());
            expS = (statQ.size() > 0) && (statQ[0].due == edgeCnt);
            chk("statvalid", (oStatValid === expS),
                $sformatf("edge %0d oStatValid=%b required %b", edgeCnt, oStatValid, expS));
            if (expS) mb = statQ.pop_front();
            while ((statQ.size() > 0) && (statQ[0].due < edgeCnt)) void'(statQ.pop_front());
            chk("stats", (oCount === 19'(mb.cnt)) && (oMinX === 10'(mb.minx)) && (oMaxX === 10'(mb.maxx)) &&
                         (oMinY === 10'(mb.miny)) && (oMaxY === 10'(mb.maxy)) && (oBoxValid === mb.bv),
                $sformatf("got cnt=%0d box=(%0d,%0d,%0d,%0d) bv=%b required cnt=%0d box=(%0d,%0d,%0d,%0d) bv=%b",
                          oCount, oMinX, oMaxX, oMinY, oMaxY, oBoxValid,
                          mb.cnt, mb.minx, mb.maxx, mb.miny, mb.maxy, mb.bv));
        end
    end

    initial begin
        logic [NPIX-1:0] r;
        clearBox();
        repeat (3) @(negedge iCLK);
        checkAllZero("reset");
        iRST_N = 1'b1;

        frame(8'h00, 1, 0);                  // all background
        idle(3);
        frame(8'b0100_0010, 0, 0);           // ones at (1,0) and (2,1)
        idle(3);
        frame(8'b0100_0010, 1, 2);           // same frame, one beat every 3 cycles
        idle(3);

        cyc(1'b1, 1'b1, 1'b1);               // aborted frame after 5 beats
        repeat (4) cyc(1'b0, 1'b1, 1'b1);
        frame(8'hFF, 1, 0);
        idle(2);

        repeat (4) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)));   // beats outside any frame

        cyc(1'b1, 1'b1, 1'b1);               // reset in the middle of a frame
        repeat (2) cyc(1'b0, 1'b1, 1'b0);
        doReset();
        r = 8'($urandom);
        frame(r, 0, -1);
        idle(2);

        r = 8'($urandom);                    // start arriving in the DONE cycle
        frame(r, 1, 0);
        cyc(1'b1, 1'b0, 1'b0);
        r = 8'($urandom);
        frame(r, 2, 0);
        idle(2);

        for (int k = 0; k < 8; k++) begin
            r = 8'($urandom);
            frame(r, int'($urandom_range(0, 1)), -1);
            idle(int'($urandom_range(0, 3)));
        end
        idle(6);
        chk("drained", (pixQ.size() == 0) && (statQ.size() == 0),
            $sformatf("pending pix=%0d stat=%0d required 0/0", pixQ.size(), statQ.size()));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/binary_mask_render.md
# binary_mask_render

Consumes the 1-bit skin/background pixel stream from the grayscale/threshold stage and turns it back into displayable 12-bit RGB pixels for the VGA/SDRAM write path. Also measures per-frame mask statistics: foreground pixel count and bounding box. It sits between the binarisation stage and the frame-buffer writer. Downstream gesture logic reads the statistics once per frame.

## Interface
- H_ACTIVE, 640, valid pixels per line
- V_ACTIVE, 480, valid lines per frame
- FG_LEVEL, 12'hFFF, R/G/B level for foreground (iBinary=1)
- BG_LEVEL, 12'h000, R/G/B level for background (iBinary=0)
- iCLK  in  1  clock; all logic on rising edge
- iRST_N  in  1  reset: asynchronous assertion, active-low
- iBinary  in  1  mask pixel, 1 = skin
- iDVAL  in  1  iBinary valid this cycle
- iFrame_Start  in  1  one-cycle pulse marking start of a frame
- oRed, oGreen, oBlue  out  12 each  rendered pixel
- oDVAL  out  1  rendered pixel valid
- oCount  out  19  foreground pixels in last completed frame
- oMinX, oMaxX, oMinY, oMaxY  out  10 each  bounding box of last completed frame
- oBoxValid  out  1  last completed frame had ≥1 foreground pixel
- oStatValid  out  1  one-cycle pulse when the stat outputs update

## Operation
- FSM states: IDLE, ACTIVE, DONE. Reset state: IDLE.
- IDLE → ACTIVE on iFrame_Start. The x/y counters and the accumulators (count, min, max) clear.
- ACTIVE:
  - Each iDVAL beat is assigned coordinate (x,y).
  - x increments and wraps from H_ACTIVE-1 to 0. y increments on the wrap.
  - If iBinary=1: count+1; minX/minY/maxX/maxY update with the current coordinate.
  - The beat at (H_ACTIVE-1, V_ACTIVE-1) moves the FSM to DONE. That beat is included in the statistics.
- DONE, one cycle:
  - Copy the accumulators to the stat outputs.
  - oBoxValid = (count≠0). If count=0, the box outputs are 0.
  - Pulse oStatValid. Go to IDLE.
- iFrame_Start while ACTIVE: abort the frame. Discard the accumulators, restart at (0,0), no oStatValid pulse. Stat outputs keep their previous values.
- iFrame_Start together with iDVAL, in IDLE or ACTIVE: that beat is pixel (0,0) of the new frame.
- iFrame_Start during DONE: the DONE update still completes. The new frame begins the next cycle, and the start is not lost.
- iDVAL outside ACTIVE: rendered normally with coordinate (0,0). Not counted.
- Rendering:
  - iBinary=1 → all channels FG_LEVEL.
  - iBinary=0 → all channels BG_LEVEL.
- Count arithmetic is unsigned 19-bit and cannot overflow for the default sizes. Min/max compares are unsigned 10-bit.

## Timing
- Rendering is a 2-stage pipeline: stage 1 registers pixel and coordinate, stage 2 registers colour. oDVAL = iDVAL delayed by exactly 2 cycles.
- Bubbles (iDVAL=0) propagate unchanged. No backpressure: a pixel is accepted every cycle iDVAL=1.
- oStatValid rises 1 cycle after the last-pixel beat. The stat outputs carry their new values in that same cycle and hold until the next update.
- Reset values:
  - All colour outputs 0, oDVAL 0.
  - oCount 0, all box outputs 0, oBoxValid 0, oStatValid 0.
  - Pipeline cleared, FSM in IDLE.
- Reset mid-frame: all state clears immediately; the partial frame produces no stats.

## Configuration
- MASK_OVERLAY_BOX_EN defined:
  - A stage-2 pixel whose coordinate lies on an edge of the currently latched box is drawn red: R=12'hFFF, G=0, B=0.
  - "On an edge" means x∈{oMinX,oMaxX} with oMinY≤y≤oMaxY, or y∈{oMinY,oMaxY} with oMinX≤x≤oMaxX.
  - Applies only when oBoxValid=1. Latency is unchanged.
- Not defined: no overlay logic; output is pure FG/BG rendering.

## Test plan
- Reset, then H_ACTIVE=4, V_ACTIVE=2, all-zero frame: expect 8 BG pixels out with oDVAL 2 cycles after each iDVAL; oStatValid pulse; oCount=0, oBoxValid=0, box outputs 0.
- 4x2 frame with 1s at (1,0) and (2,1): expect oCount=2, oMinX=1, oMaxX=2, oMinY=0, oMaxY=1, oBoxValid=1. oStatValid occurs 1 cycle after beat 8.
- Gapped iDVAL (1 valid every 3 cycles): oDVAL pattern is identical shifted by 2 cycles; stats are the same as the gapless run.
- iFrame_Start after 5 beats of a frame, then a full all-ones frame: no pulse for the aborted frame; then oCount=8, box (0,3,0,1).
- Assert iRST_N low mid-frame: all outputs 0 asynchronously; the next full frame reports correct stats.
- With MASK_OVERLAY_BOX_EN and latched box (1,2,0,1): pixel (1,0) renders 12'hFFF/0/0 and pixel (0,0) renders FG/BG. Without the macro, both render FG/BG.
